// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader: receives a framed, checksummed program byte stream, writes it into
// instruction memory and releases the core. Define LOADER_REBOOT_EN to allow reloading from RUN.
module prog_loader #(
  parameter int IMEM_AW = 10
) (
  input  logic               in_Clk,
  input  logic               in_Rst,
  input  logic [7:0]         in_rx_data,
  input  logic               in_rx_valid,
  output logic               out_rx_ready,
  output logic               out_IM_wr_en,
  output logic [IMEM_AW-1:0] out_IM_addr,
  output logic [31:0]        out_IM_wr_data,
  output logic [63:0]        out_PC,
  output logic               out_load_init_addr,
  output logic               out_core_Rst_N,
  output logic               out_busy,
  output logic               out_error
);

`ifdef LOADER_REBOOT_EN
  localparam bit REBOOT = 1'b1;
`else
  localparam bit REBOOT = 1'b0;
`endif

  localparam logic [7:0]  MAGIC = 8'hA5;
  localparam logic [16:0] CAP   = 17'd1 << IMEM_AW;

  typedef enum logic [2:0] {
    S_IDLE, S_PC, S_LEN, S_DATA, S_CSUM, S_LOAD, S_RUN, S_ERROR
  } state_e;

  state_e             state_q;
  logic [7:0]         sum_q, sum_d;
  logic [2:0]         cnt_q;
  logic [15:0]        widx_q;
  logic [15:0]        n_q, n_d;
  logic [63:0]        pc_q, pc_d;
  logic [23:0]        word_q;
  logic [31:0]        word_d;
  logic               wr_en_q;
  logic [IMEM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic               accept;
  logic               last_word;
  logic               in_run;

  always_comb begin
    in_run       = (state_q == S_LOAD) || (state_q == S_RUN);
    out_rx_ready = (state_q inside {S_IDLE, S_PC, S_LEN, S_DATA, S_CSUM}) ||
                   (REBOOT && (state_q == S_RUN));
    accept       = in_rx_valid && out_rx_ready;
    sum_d        = sum_q + in_rx_data;
    pc_d         = {in_rx_data, pc_q[63:8]};
    n_d          = {in_rx_data, n_q[7:0]};
    word_d       = {in_rx_data, word_q};
    last_word    = ((widx_q + 16'd1) == n_q);
  end

  assign out_busy           = state_q inside {S_PC, S_LEN, S_DATA, S_CSUM, S_LOAD};
  assign out_error          = (state_q == S_ERROR);
  assign out_core_Rst_N     = in_run;
  assign out_load_init_addr = (state_q == S_LOAD);
  // pc_q is reused as the shift register during collection, so expose it only once loaded.
  assign out_PC             = in_run ? pc_q : 64'd0;
  assign out_IM_wr_en       = wr_en_q;
  assign out_IM_addr        = addr_q;
  assign out_IM_wr_data     = wdata_q;

  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      state_q <= S_IDLE;
      sum_q   <= 8'd0;
      cnt_q   <= 3'd0;
      widx_q  <= 16'd0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RUN: begin
          // RUN only accepts bytes when reloading is enabled, via out_rx_ready.
          if (accept && (in_rx_data == MAGIC)) begin
            sum_q   <= 8'd0;
            cnt_q   <= 3'd0;
            widx_q  <= 16'd0;
            state_q <= S_PC;
          end
        end
        S_PC: begin
          if (accept) begin
            pc_q  <= pc_d;
            sum_q <= sum_d;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              cnt_q   <= 3'd0;
              state_q <= (pc_d[1:0] != 2'b00) ? S_ERROR : S_LEN;
            end
          end
        end
        S_LEN: begin
          if (accept) begin
            sum_q <= sum_d;
            if (cnt_q == 3'd0) begin
              n_q[7:0] <= in_rx_data;
              cnt_q    <= 3'd1;
            end else begin
              n_q   <= n_d;
              cnt_q <= 3'd0;
              if ({1'b0, n_d} > CAP)   state_q <= S_ERROR;
              else if (n_d == 16'd0)   state_q <= S_CSUM;
              else                     state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            sum_q  <= sum_d;
            word_q <= word_d[31:8];
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q == 3'd3) begin
              cnt_q   <= 3'd0;
              wr_en_q <= 1'b1;
              addr_q  <= widx_q[IMEM_AW-1:0];
              wdata_q <= word_d;
              widx_q  <= widx_q + 16'd1;
              if (last_word) state_q <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept) state_q <= (in_rx_data == sum_q) ? S_LOAD : S_ERROR;
        end
        S_LOAD:  state_q <= S_RUN;
        S_ERROR: state_q <= S_ERROR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
// Bench for prog_loader: vector table of whole frames, hand-timed corner cases,
// and randomized frames checked against a frame-parsing reference model.
module tb_prog_loader;

`ifdef LOADER_REBOOT_EN
  localparam bit REBOOT = 1'b1;
`else
  localparam bit REBOOT = 1'b0;
`endif

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct packed {
    logic [255:0] b;
    int           len;
    int           oc;
    logic [63:0]  pc;
    int           nw;
    logic [31:0]  w0;
    logic [31:0]  w1;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;

  logic        ready1, wr_en1, lia1, crn1, busy1, err1;
  logic [9:0]  addr1;
  logic [31:0] wdata1;
  logic [63:0] pc1;
  logic        ready2, wr_en2, lia2, crn2, busy2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [63:0] pc2;

  prog_loader #(.IMEM_AW(10)) dut (
    .in_Clk(clk), .in_Rst(rst), .in_rx_data(rx_data), .in_rx_valid(rx_valid),
    .out_rx_ready(ready1), .out_IM_wr_en(wr_en1), .out_IM_addr(addr1),
    .out_IM_wr_data(wdata1), .out_PC(pc1), .out_load_init_addr(lia1),
    .out_core_Rst_N(crn1), .out_busy(busy1), .out_error(err1));

  prog_loader #(.IMEM_AW(2)) dut_small (
    .in_Clk(clk), .in_Rst(rst), .in_rx_data(rx_data), .in_rx_valid(rx_valid),
    .out_rx_ready(ready2), .out_IM_wr_en(wr_en2), .out_IM_addr(addr2),
    .out_IM_wr_data(wdata2), .out_PC(pc2), .out_load_init_addr(lia2),
    .out_core_Rst_N(crn2), .out_busy(busy2), .out_error(err2));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wa_q[$];
  wq_t         wd_q;
  int          wc_q[$];
  int          lp_cnt = 0;
  logic [63:0] lp_pc = 64'd0;

  always @(negedge clk) begin
    if (wr_en1) begin
      wa_q.push_back(int'(addr1));
      wd_q.push_back(wdata1);
      wc_q.push_back(cyc);
    end
    if (lia1) begin
      lp_cnt = lp_cnt + 1;
      lp_pc  = pc1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    lp_cnt = 0; lp_pc = 64'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    clear_mon();
  endtask

  // One byte presented for exactly one cycle after `gap` idle cycles.
  task automatic send(input logic [7:0] b, input int gap);
    idle(gap);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic send_q(input bq_t q, input int maxgap);
    foreach (q[i]) send(q[i], $urandom_range(0, maxgap));
  endtask

  // Parse a stream as the frame rules describe: oc 0 = incomplete, 1 = loaded, 2 = error.
  function automatic void model(input bq_t s, input int aw, output int oc,
                                output logic [63:0] pc, output wq_t w);
    int i, n;
    logic [7:0] sum;
    logic [31:0] word;
    oc = 0; pc = 64'd0; w.delete(); sum = 8'd0; i = 0;
    while (i < s.size() && s[i] != 8'hA5) i++;
    i++;
    if (i + 8 > s.size()) return;
    for (int k = 0; k < 8; k++) begin
      pc  = pc | (64'(s[i+k]) << (8*k));
      sum = sum + s[i+k];
    end
    i += 8;
    if (pc[1:0] != 2'b00) begin oc = 2; return; end
    if (i + 2 > s.size()) return;
    n   = int'(s[i]) + 256 * int'(s[i+1]);
    sum = sum + s[i] + s[i+1];
    i += 2;
    if (n > (1 << aw)) begin oc = 2; return; end
    for (int k = 0; k < n; k++) begin
      if (i + 4 > s.size()) return;
      word = 32'd0;
      for (int j = 0; j < 4; j++) begin
        word = word | (32'(s[i+j]) << (8*j));
        sum  = sum + s[i+j];
      end
      w.push_back(word);
      i += 4;
    end
    if (i >= s.size()) return;
    oc = (s[i] == sum) ? 1 : 2;
  endfunction

  task automatic check_result(input string tag, input int oc, input logic [63:0] pc,
                              input wq_t w);
    logic exp_rdy;
    exp_rdy = (oc == 1) ? REBOOT : ((oc == 2) ? 1'b0 : 1'b1);
    chk({tag, ".nwr"}, 64'(wd_q.size()), 64'(w.size()));
    for (int k = 0; k < w.size() && k < wd_q.size(); k++) begin
      chk({tag, ".addr"}, 64'(wa_q[k]), 64'(k));
      chk({tag, ".wdata"}, 64'(wd_q[k]), 64'(w[k]));
    end
    chk({tag, ".loads"}, 64'(lp_cnt), (oc == 1) ? 64'd1 : 64'd0);
    if (oc == 1) chk({tag, ".pc"}, lp_pc, pc);
    chk({tag, ".error"}, 64'(err1), (oc == 2) ? 64'd1 : 64'd0);
    chk({tag, ".core_rst_n"}, 64'(crn1), (oc == 1) ? 64'd1 : 64'd0);
    chk({tag, ".ready"}, 64'(ready1), 64'(exp_rdy));
    if (oc != 0) chk({tag, ".busy"}, 64'(busy1), 64'd0);
  endtask

  vec_t vt[6];

  task automatic setv(input int idx, input bq_t q, input int oc, input logic [63:0] pc,
                      input int nw, input logic [31:0] w0, input logic [31:0] w1);
    vt[idx] = '0;
    foreach (q[i]) vt[idx].b[8*i +: 8] = q[i];
    vt[idx].len = q.size();
    vt[idx].oc = oc; vt[idx].pc = pc; vt[idx].nw = nw;
    vt[idx].w0 = w0; vt[idx].w1 = w1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t f0, f1, f2, f3, f4, f5, s;
    wq_t ew;
    int oc, n;
    logic [63:0] pc;
    logic [7:0] b, cs;

    f0 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
           8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h89};
    f1 = f0; f1[19] = 8'h88;
    f2 = '{8'h00, 8'h13};
    foreach (f0[i]) f2.push_back(f0[i]);
    f3 = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
    f4 = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    f5 = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h01, 8'h00,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hBD};
    setv(0, f0, 1, 64'h0, 2, 32'h00500093, 32'h00108113);
    setv(1, f1, 2, 64'h0, 2, 32'h00500093, 32'h00108113);
    setv(2, f2, 1, 64'h0, 2, 32'h00500093, 32'h00108113);
    setv(3, f3, 1, 64'h1000, 0, 32'h0, 32'h0);
    setv(4, f4, 2, 64'h0, 0, 32'h0, 32'h0);
    setv(5, f5, 1, 64'h8000_0000_0000_0004, 1, 32'hDEADBEEF, 32'h0);

    // Reset values, during and on the cycle after reset.
    rst = 1'b1;
    idle(1);
    chk("rst.state_ready", 64'(ready1), 64'd1);
    chk("rst.wr_en", 64'(wr_en1), 64'd0);
    chk("rst.core_rst_n", 64'(crn1), 64'd0);
    idle(1);
    rst = 1'b0;
    chk("rst.addr", 64'(addr1), 64'd0);
    chk("rst.wdata", 64'(wdata1), 64'd0);
    chk("rst.pc", pc1, 64'd0);
    chk("rst.load", 64'(lia1), 64'd0);
    chk("rst.busy", 64'(busy1), 64'd0);
    chk("rst.error", 64'(err1), 64'd0);
    clear_mon();

    // Table-driven frames with random bubbles.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < vt[v].len; i++) send(vt[v].b[8*i +: 8], $urandom_range(0, 2));
      idle(3);
      ew.delete();
      if (vt[v].nw > 0) ew.push_back(vt[v].w0);
      if (vt[v].nw > 1) ew.push_back(vt[v].w1);
      check_result($sformatf("vec%0d", v), vt[v].oc, vt[v].pc, ew);
    end

    // Back-to-back timing: writes every 4 cycles, write overlapping CSUM, one-cycle LOAD.
    do_reset();
    foreach (f0[i]) begin
      send(f0[i], 0);
      if (i == 14) begin
        chk("b2b.wr0_en", 64'(wr_en1), 64'd1);
        chk("b2b.wr0_addr", 64'(addr1), 64'd0);
      end
      if (i == 15) chk("b2b.wr0_one_cycle", 64'(wr_en1), 64'd0);
      if (i == 18) begin
        chk("b2b.wr1_en", 64'(wr_en1), 64'd1);
        chk("b2b.wr1_data", 64'(wdata1), 64'h00108113);
        chk("b2b.csum_ready", 64'(ready1), 64'd1);
        chk("b2b.pre_load_rst_n", 64'(crn1), 64'd0);
      end
      if (i == 19) begin
        chk("b2b.load", 64'(lia1), 64'd1);
        chk("b2b.load_rst_n", 64'(crn1), 64'd1);
        chk("b2b.load_busy", 64'(busy1), 64'd1);
      end
    end
    if (wc_q.size() == 2) chk("b2b.wr_spacing", 64'(wc_q[1] - wc_q[0]), 64'd4);
    else chk("b2b.wr_count", 64'(wc_q.size()), 64'd2);
    idle(1);
    chk("run.load_drop", 64'(lia1), 64'd0);
    chk("run.rst_n", 64'(crn1), 64'd1);
    chk("run.busy", 64'(busy1), 64'd0);

    // RUN: a new 0xA5 restarts loading only when reloading is enabled.
    send(8'hA5, 0);
    chk("rb.core_rst_n", 64'(crn1), REBOOT ? 64'd0 : 64'd1);
    chk("rb.busy", 64'(busy1), REBOOT ? 64'd1 : 64'd0);
    for (int i = 1; i < f5.size(); i++) send(f5[i], $urandom_range(0, 1));
    idle(2);
    chk("rb.loads", 64'(lp_cnt), REBOOT ? 64'd2 : 64'd1);
    chk("rb.pc", pc1, REBOOT ? 64'h8000_0000_0000_0004 : 64'd0);
    chk("rb.nwr", 64'(wd_q.size()), REBOOT ? 64'd3 : 64'd2);

    // Checksum mismatch timing.
    do_reset();
    for (int i = 0; i < 19; i++) send(f1[i], 0);
    chk("bad_csum.pre_err", 64'(err1), 64'd0);
    send(f1[19], 0);
    chk("bad_csum.err", 64'(err1), 64'd1);
    chk("bad_csum.load", 64'(lia1), 64'd0);
    chk("bad_csum.ready", 64'(ready1), 64'd0);

    // Misaligned PC flagged right after the 8th PC byte.
    do_reset();
    for (int i = 0; i < 8; i++) send(f4[i], 0);
    chk("pc_align.pre_err", 64'(err1), 64'd0);
    send(f4[8], 0);
    chk("pc_align.err", 64'(err1), 64'd1);
    chk("pc_align.nwr", 64'(wd_q.size()), 64'd0);

    // Word count against a 4-word memory: N=4 fits, N=5 is rejected.
    do_reset();
    send(8'hA5, 0);
    for (int i = 0; i < 8; i++) send(8'h00, 0);
    send(8'h04, 0); send(8'h00, 0);
    chk("cap4.err", 64'(err2), 64'd0);
    chk("cap4.busy", 64'(busy2), 64'd1);
    do_reset();
    send(8'hA5, 0);
    for (int i = 0; i < 8; i++) send(8'h00, 0);
    send(8'h05, 0);
    chk("cap5.pre_err", 64'(err2), 64'd0);
    send(8'h00, 0);
    chk("cap5.err", 64'(err2), 64'd1);
    chk("cap5.ready", 64'(ready2), 64'd0);
    chk("cap5.big_mem_ok", 64'(err1), 64'd0);

    // Reset in the middle of DATA: the next frame restarts at word 0.
    do_reset();
    for (int i = 0; i < 11; i++) send(f0[i], 0);
    s = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_q(s, 1);
    chk("midrst.nwr", 64'(wd_q.size()), 64'd1);
    if (wd_q.size() > 0) chk("midrst.w0", 64'(wd_q[0]), 64'h44332211);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst.busy", 64'(busy1), 64'd0);
    chk("midrst.ready", 64'(ready1), 64'd1);
    chk("midrst.core_rst_n", 64'(crn1), 64'd0);
    clear_mon();
    send_q(f0, 2);
    idle(2);
    model(f0, 10, oc, pc, ew);
    check_result("midrst.reload", oc, pc, ew);

    // Randomized frames against the reference model.
    for (int t = 0; t < 40; t++) begin
      s.delete(); cs = 8'd0;
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        s.push_back(b);
      end
      s.push_back(8'hA5);
      pc = {$urandom, $urandom};
      pc[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      for (int k = 0; k < 8; k++) begin
        b = pc[8*k +: 8]; s.push_back(b); cs = cs + b;
      end
      n = $urandom_range(0, 5);
      s.push_back(8'(n)); s.push_back(8'h00); cs = cs + 8'(n);
      for (int k = 0; k < 4 * n; k++) begin
        b = 8'($urandom); s.push_back(b); cs = cs + b;
      end
      if ($urandom_range(0, 5) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      s.push_back(cs);
      model(s, 10, oc, pc, ew);
      do_reset();
      send_q(s, 3);
      idle(3);
      check_result($sformatf("rand%0d", t), oc, pc, ew);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
